// File: rtl/parallel_tx_arbiter.sv
// Round-robin arbiter that shares one parallel-to-serial interface among NUM_REQ requesters.
// Grant one cycle after req is sampled in IDLE; requesters wait (no grant) while a word is in flight.
module parallel_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 32,
  parameter int ID_W          = $clog2(NUM_REQ),
  parameter int GRANT_TIMEOUT = 8,
  parameter int DONE_TIMEOUT  = 64
) (
  input  logic                      p_clk,
  input  logic                      n_rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      pi_req,
  output logic [DATA_W-1:0]         pi_data,
  input  logic                      pi_grant,
  input  logic                      pi_active,
  output logic                      busy,
  output logic [ID_W-1:0]           cur_id,
  output logic                      err,
  output logic                      err_stage
);

  localparam int CNT_MAX = (GRANT_TIMEOUT > DONE_TIMEOUT) ? GRANT_TIMEOUT : DONE_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  state_t              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     cur_id_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                active_seen_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  done_q;
  logic                pi_req_q;
  logic [DATA_W-1:0]   pi_data_q;
  logic                err_q;
  logic                err_stage_q;

  logic                win_vld;
  logic [ID_W-1:0]     win_id;

  // First requester above the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge p_clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      ptr_q         <= ID_W'(NUM_REQ - 1);
      cur_id_q      <= '0;
      cnt_q         <= '0;
      active_seen_q <= 1'b0;
      grant_q       <= '0;
      done_q        <= '0;
      pi_req_q      <= 1'b0;
      pi_data_q     <= '0;
      err_q         <= 1'b0;
      err_stage_q   <= 1'b0;
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q   <= ISSUE;
            grant_q   <= NUM_REQ'(1) << win_id;
            pi_req_q  <= 1'b1;
            pi_data_q <= data_in[int'(win_id)*DATA_W +: DATA_W];
            cur_id_q  <= win_id;
            ptr_q     <= win_id;
            cnt_q     <= '0;
          end
        end
        ISSUE: begin
          if (pi_grant) begin
            pi_req_q      <= 1'b0;
            cnt_q         <= '0;
            active_seen_q <= 1'b0;
            state_q       <= WAIT_DONE;
          end else if (cnt_q == CNT_W'(GRANT_TIMEOUT - 1)) begin
            err_q       <= 1'b1;
            err_stage_q <= 1'b0;
            pi_req_q    <= 1'b0;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (pi_active) active_seen_q <= 1'b1;
          // Completion is the falling edge of the serializer's active window.
          if (active_seen_q && !pi_active) begin
            done_q  <= NUM_REQ'(1) << cur_id_q;
            state_q <= GAP;
          end else if (cnt_q == CNT_W'(DONE_TIMEOUT - 1)) begin
            err_q       <= 1'b1;
            err_stage_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign pi_req    = pi_req_q;
  assign pi_data   = pi_data_q;
  assign busy      = (state_q != IDLE);
  assign cur_id    = cur_id_q;
  assign err       = err_q;
  assign err_stage = err_stage_q;

endmodule

// File: tb/tb_parallel_tx_arbiter.sv
// Bench for parallel_tx_arbiter: lockstep stimulus on falling edges, round-robin reference model.
module tb_parallel_tx_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           p_clk = 1'b0;
  logic           n_rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   grant, done;
  logic           pi_req;
  logic [W-1:0]   pi_data;
  logic           pi_grant, pi_active;
  logic           busy;
  logic [1:0]     cur_id;
  logic           err, err_stage;

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr;
  int exp_id;
  logic [W-1:0] exp_word;

  parallel_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .ID_W(2), .GRANT_TIMEOUT(8), .DONE_TIMEOUT(64)) dut (
    .p_clk(p_clk), .n_rst(n_rst), .req(req), .data_in(data_in),
    .grant(grant), .done(done), .pi_req(pi_req), .pi_data(pi_data),
    .pi_grant(pi_grant), .pi_active(pi_active), .busy(busy), .cur_id(cur_id),
    .err(err), .err_stage(err_stage)
  );

  always #5 p_clk = ~p_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++)
      if (m[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic step();
    @(negedge p_clk);
  endtask

  // Present a request in IDLE and check the grant cycle.
  task automatic start_xfer(input logic [N-1:0] mask, input bit rand_data);
    if (rand_data)
      for (int i = 0; i < N; i++) data_in[i*W +: W] = $urandom;
    req      = mask;
    exp_id   = rr_pick(model_ptr, mask);
    exp_word = data_in[exp_id*W +: W];
    step();
    chk("grant", grant, N'(1) << exp_id);
    chk("cur_id", cur_id, exp_id);
    chk("pi_data", pi_data, exp_word);
    chk("pi_req_set", pi_req, 1);
    chk("busy_issue", busy, 1);
    model_ptr = exp_id;
  endtask

  // Serializer behaviour: grant after g cycles, idle p cycles, active a cycles.
  task automatic finish_xfer(input int g, input int p, input int a, input bit noise, input bit hold);
    for (int d = 0; d <= g; d++) begin
      chk("pi_req_issue", pi_req, 1);
      chk("pi_data_hold", pi_data, exp_word);
      if (d > 0) chk("grant_once", grant, 0);
      pi_grant  = (d == g);
      pi_active = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!hold) begin
        req = N'($urandom);
        for (int i = 0; i < N; i++) data_in[i*W +: W] = $urandom;
      end
      step();
    end
    pi_grant = 1'b0;
    for (int w = 0; w <= p + a; w++) begin
      if (w == 0) chk("pi_req_drop", pi_req, 0);
      chk("done_early", done, 0);
      chk("err_none", err, 0);
      pi_active = (w >= p && w < p + a);
      step();
    end
    pi_active = 1'b0;
    chk("done", done, N'(1) << exp_id);
    chk("busy_gap", busy, 1);
    step();
    chk("done_once", done, 0);
    chk("busy_idle", busy, 0);
    if (!hold) req = '0;
  endtask

  initial begin
    n_rst = 1'b1; req = '0; data_in = '0; pi_grant = 1'b0; pi_active = 1'b0;
    #1 n_rst = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_pi_req", pi_req, 0);
    chk("rst_pi_data", pi_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_id", cur_id, 0);
    chk("rst_err", err, 0);
    chk("rst_err_stage", err_stage, 0);
    step();
    n_rst = 1'b1;
    model_ptr = N - 1;

    // All requesters held high: 0,1,2,3,0.
    for (int t = 0; t < 5; t++) begin
      start_xfer(4'b1111, 1);
      chk("allreq_order", cur_id, t % N);
      finish_xfer(1, 1, 4, 0, 1);
    end
    req = '0;
    step();

    // Fairness after idle.
    start_xfer(4'b0100, 1); finish_xfer(0, 0, 3, 0, 0);
    start_xfer(4'b0011, 1); finish_xfer(2, 2, 5, 1, 0);
    start_xfer(4'b0101, 1); finish_xfer(3, 1, 2, 1, 0);

    // Single request with a fixed word.
    data_in = '0;
    data_in[31:0] = 32'hA5A5_0F0F;
    start_xfer(4'b0001, 0);
    finish_xfer(2, 1, 34, 0, 0);

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      start_xfer(N'($urandom_range(1, 15)), 1);
      finish_xfer($urandom_range(0, 7), $urandom_range(0, 8), $urandom_range(1, 30), 1, 0);
    end

    // Grant timeout.
    start_xfer(N'($urandom_range(1, 15)), 1);
    req = '0;
    for (int d = 0; d < 8; d++) begin
      chk("gto_pi_req", pi_req, 1);
      chk("gto_err_early", err, 0);
      pi_active = 1'($urandom_range(0, 1));
      step();
    end
    pi_active = 1'b0;
    chk("gto_err", err, 1);
    chk("gto_err_stage", err_stage, 0);
    chk("gto_pi_req_low", pi_req, 0);
    chk("gto_busy", busy, 0);
    chk("gto_no_done", done, 0);
    step();
    chk("gto_err_once", err, 0);
    chk("gto_stay_idle", busy, 0);
    start_xfer(N'($urandom_range(1, 15)), 1);
    finish_xfer(1, 2, 6, 0, 0);

    // Done timeout.
    start_xfer(N'($urandom_range(1, 15)), 1);
    req = '0;
    pi_grant = 1'b1;
    step();
    pi_grant = 1'b0;
    pi_active = 1'b1;
    for (int w = 0; w < 64; w++) begin
      chk("dto_no_done", done, 0);
      chk("dto_err_early", err, 0);
      step();
    end
    chk("dto_err", err, 1);
    chk("dto_err_stage", err_stage, 1);
    chk("dto_busy", busy, 0);
    chk("dto_no_done_end", done, 0);
    pi_active = 1'b0;
    step();
    chk("dto_err_once", err, 0);

    // Reset while in ISSUE: pi_req must fall without a clock edge.
    start_xfer(4'b0010, 1);
    req = '0;
    #2 n_rst = 1'b0;
    #1;
    chk("arst_issue_pi_req", pi_req, 0);
    chk("arst_issue_busy", busy, 0);
    step();
    n_rst = 1'b1;
    model_ptr = N - 1;

    // Reset while in WAIT_DONE.
    start_xfer(4'b0100, 1);
    req = '0;
    pi_grant = 1'b1;
    step();
    pi_grant = 1'b0;
    pi_active = 1'b1;
    step();
    step();
    #2 n_rst = 1'b0;
    #1;
    chk("arst_wait_pi_req", pi_req, 0);
    chk("arst_wait_busy", busy, 0);
    chk("arst_wait_grant", grant, 0);
    chk("arst_wait_done", done, 0);
    chk("arst_wait_err", err, 0);
    chk("arst_wait_cur_id", cur_id, 0);
    pi_active = 1'b0;
    step();
    step();
    chk("arst_hold_done", done, 0);
    n_rst = 1'b1;
    model_ptr = N - 1;
    start_xfer(4'b1111, 1);
    chk("arst_ptr_winner", cur_id, 0);
    finish_xfer(0, 1, 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/parallel_tx_arbiter.md
Name: parallel_tx_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one parallel-to-serial interface among NUM_REQ requesters.
- Accepts one 32-bit word per grant and drives the serializer's req/data handshake.
- Tracks the serializer's out_data (active) window and reports per-requester completion.
- Watchdogs flag a stalled serializer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, word width; must match the serializer input
- ID_W, 2, requester index width, equals clog2(NUM_REQ)
- GRANT_TIMEOUT, 8, max cycles in ISSUE waiting for pi_grant
- DONE_TIMEOUT, 64, max cycles in WAIT_DONE waiting for the active window to close

Ports:
- p_clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- req  in  NUM_REQ  level request per requester; data must be held until that requester's grant pulse
- data_in  in  NUM_REQ*DATA_W  requester words; requester i occupies bits [i*DATA_W +: DATA_W]
- grant  out  NUM_REQ  one-hot, 1-cycle pulse: word latched
- done  out  NUM_REQ  one-hot, 1-cycle pulse: word fully serialized
- pi_req  out  1  request to serializer
- pi_data  out  DATA_W  latched word to serializer
- pi_grant  in  1  serializer grant
- pi_active  in  1  serializer out_data (high while loading/shifting)
- busy  out  1  high whenever state != IDLE
- cur_id  out  ID_W  index of the owner of the latched word
- err  out  1  1-cycle timeout pulse
- err_stage  out  1  0 = grant timeout, 1 = done timeout; valid with err

Behaviour:
- Clock/reset: one clock, p_clk. Reset n_rst is asynchronous, active-low.
- Reset values:
  - State IDLE; all outputs 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - Watchdog counter 0; active_seen 0.
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - If any req bit is set, select the first set bit scanning upward from pointer+1 modulo NUM_REQ.
  - On that edge: latch data_in slice into pi_data, winner into cur_id, pointer := winner; pulse grant[winner] next cycle; go ISSUE.
  - No req -> stay; pi_req = 0.
- ISSUE:
  - pi_req = 1; pi_data held stable.
  - On a cycle with pi_grant = 1: deassert pi_req registered (low next cycle), clear counter, go WAIT_DONE.
  - Counter reaches GRANT_TIMEOUT without pi_grant: err = 1, err_stage = 0, pi_req = 0, go IDLE. No done pulse.
- WAIT_DONE:
  - pi_req = 0.
  - Set active_seen when pi_active = 1.
  - On a cycle with active_seen = 1 and pi_active = 0: pulse done[cur_id], go GAP.
  - Counter reaches DONE_TIMEOUT: err = 1, err_stage = 1, go IDLE.
- GAP: one cycle, lets the serializer settle in its IDLE; then go IDLE. Back-to-back words are therefore separated by at least one idle cycle.
- Latency: req sampled at edge N -> grant pulse cycle N+1, pi_req high cycle N+1; with a compliant serializer, done pulses about 36 cycles after grant.
- Arbitration timing:
  - Arbitration happens only in IDLE.
  - req changes during ISSUE/WAIT_DONE/GAP are ignored until return to IDLE.
  - Dropping req after grant does not cancel the transfer.
- Simultaneous requests: exactly one winner, per the round-robin rule. With all requesters continuously requesting, grant order is 0,1,2,3,0,...
- Timeout: the pointer has already advanced, so the failed requester is not retried first.
- pi_active high while in ISSUE (before grant) is ignored; active_seen is cleared on entry to WAIT_DONE.
- Reset mid-transfer: immediate return to reset values; no done/err pulse; pi_req drops asynchronously.
- grant, done and err are never high for more than one cycle per transfer.

Test Plan:
- Single request: req=0001, data0=32'hA5A5_0F0F -> grant=0001 one cycle later, pi_data=A5A5_0F0F, pi_req high until pi_grant; done=0001 after pi_active 1->0; busy low after GAP.
- All request: req=1111 held -> grants in order 0001,0010,0100,1000,0001; cur_id sequence 0,1,2,3,0; GAP cycle between each.
- Fairness after idle: last winner 2; then req=0011 -> winner 0 before 1; then req=0101 -> winner 2.
- Grant timeout: pi_grant tied 0 -> after 8 cycles in ISSUE, err=1, err_stage=0, pi_req=0, no done; next request served normally.
- Done timeout: pi_active stuck 1 -> err=1, err_stage=1 after 64 cycles; state IDLE.
- Reset mid-WAIT_DONE: n_rst low asynchronously -> pi_req, busy, grant, done, err all 0 without clock; pointer reset so requester 0 wins next.
